rnic_lite_reg_slave: RTL

- AXI4-Lite slave register bank; the responder end of the AXI-Lite configuration master used in the RNIC example design.
- Holds NUM_RW_REGS read/write 32-bit configuration registers and exposes them as a flat bus to datapath logic.
- Returns four read-only 16-bit status counters, such as packet/ACK counts, at fixed offsets above the RW region.
- Standalone stand-in for XRNIC register space in bring-up and loopback benches.

---
 rtl/rnic_lite_reg_slave.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/rnic_lite_reg_slave.sv
// AXI4-Lite register slave: NUM_RW_REGS RW config registers exposed as a flat bus,
// plus four RO 16-bit status counters mapped directly above the RW region.
module rnic_lite_reg_slave #(
  parameter int unsigned C_S_AXI_LITE_ADDR_WIDTH = 32,
  parameter int unsigned C_S_AXI_LITE_DATA_WIDTH = 32,
  parameter int unsigned NUM_RW_REGS             = 16,
  parameter logic [31:0] BASE_ADDR               = 32'h0002_0000
) (
  input  logic                                             s_axi_lite_aclk,
  input  logic                                             s_axi_lite_arst,
  input  logic [C_S_AXI_LITE_ADDR_WIDTH-1:0]               s_axi_lite_awaddr,
  input  logic                                             s_axi_lite_awvalid,
  output logic                                             s_axi_lite_awready,
  input  logic [C_S_AXI_LITE_DATA_WIDTH-1:0]               s_axi_lite_wdata,
  input  logic [C_S_AXI_LITE_DATA_WIDTH/8-1:0]             s_axi_lite_wstrb,
  input  logic                                             s_axi_lite_wvalid,
  output logic                                             s_axi_lite_wready,
  output logic [1:0]                                       s_axi_lite_bresp,
  output logic                                             s_axi_lite_bvalid,
  input  logic                                             s_axi_lite_bready,
  input  logic [C_S_AXI_LITE_ADDR_WIDTH-1:0]               s_axi_lite_araddr,
  input  logic                                             s_axi_lite_arvalid,
  output logic                                             s_axi_lite_arready,
  output logic [C_S_AXI_LITE_DATA_WIDTH-1:0]               s_axi_lite_rdata,
  output logic [1:0]                                       s_axi_lite_rresp,
  output logic                                             s_axi_lite_rvalid,
  input  logic                                             s_axi_lite_rready,
  input  logic [15:0]                                      num_send_pkt_rcvd,
  input  logic [15:0]                                      num_rd_resp_pkt_rcvd,
  input  logic [15:0]                                      num_rdma_rd_wr_wqe,
  input  logic [15:0]                                      num_ack_rcvd,
  output logic [C_S_AXI_LITE_DATA_WIDTH*NUM_RW_REGS-1:0]   reg_out,
  output logic [NUM_RW_REGS-1:0]                           reg_wr_pulse
);

  localparam int unsigned AddrW = C_S_AXI_LITE_ADDR_WIDTH;
  localparam int unsigned DataW = C_S_AXI_LITE_DATA_WIDTH;
  localparam int unsigned StrbW = DataW / 8;
  localparam int unsigned IdxW  = (NUM_RW_REGS > 1) ? $clog2(NUM_RW_REGS) : 1;
  localparam logic [AddrW-1:0] Base   = AddrW'(BASE_ADDR);
  localparam logic [AddrW-1:0] NumRw  = AddrW'(NUM_RW_REGS);
  localparam logic [AddrW-1:0] NumAll = AddrW'(NUM_RW_REGS + 4);
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] RespDecErr = 2'b11;

  typedef enum logic [1:0] {WR_IDLE, WR_HAVE_ADDR, WR_HAVE_DATA, WR_RESP} wr_state_e;
  typedef enum logic {RD_IDLE, RD_RESP} rd_state_e;

  wr_state_e          r_wr_state, w_wr_state_nxt;
  rd_state_e          r_rd_state, w_rd_state_nxt;
  logic [DataW-1:0]   r_regs [NUM_RW_REGS];
  logic [NUM_RW_REGS-1:0] r_wr_pulse;
  logic [AddrW-1:0]   r_awaddr;
  logic [DataW-1:0]   r_wdata;
  logic [StrbW-1:0]   r_wstrb;
  logic [1:0]         r_bresp;
  logic [DataW-1:0]   r_rdata;
  logic [1:0]         r_rresp;

  logic               w_commit;
  logic [AddrW-1:0]   w_wr_addr, w_wr_idx, w_rd_idx;
  logic [DataW-1:0]   w_wr_data, w_rd_data;
  logic [StrbW-1:0]   w_wr_strb;
  logic [1:0]         w_wr_resp, w_rd_resp;

  // Write FSM
  always_ff @(posedge s_axi_lite_aclk or posedge s_axi_lite_arst) begin
    if (s_axi_lite_arst) r_wr_state <= WR_IDLE;
    else                 r_wr_state <= w_wr_state_nxt;
  end

  always_comb begin
    w_wr_state_nxt     = r_wr_state;
    s_axi_lite_awready = 1'b0;
    s_axi_lite_wready  = 1'b0;
    w_commit           = 1'b0;
    unique case (r_wr_state)
      WR_IDLE: begin
        s_axi_lite_awready = 1'b1;
        s_axi_lite_wready  = 1'b1;
        if (s_axi_lite_awvalid && s_axi_lite_wvalid) begin
          w_commit       = 1'b1;
          w_wr_state_nxt = WR_RESP;
        end else if (s_axi_lite_awvalid) begin
          w_wr_state_nxt = WR_HAVE_ADDR;
        end else if (s_axi_lite_wvalid) begin
          w_wr_state_nxt = WR_HAVE_DATA;
        end
      end
      WR_HAVE_ADDR: begin
        s_axi_lite_wready = 1'b1;
        if (s_axi_lite_wvalid) begin
          w_commit       = 1'b1;
          w_wr_state_nxt = WR_RESP;
        end
      end
      WR_HAVE_DATA: begin
        s_axi_lite_awready = 1'b1;
        if (s_axi_lite_awvalid) begin
          w_commit       = 1'b1;
          w_wr_state_nxt = WR_RESP;
        end
      end
      WR_RESP: begin
        if (s_axi_lite_bready) w_wr_state_nxt = WR_IDLE;
      end
    endcase
  end

  // The second handshake supplies one half live; the other half comes from the capture regs.
  assign w_wr_addr = (r_wr_state == WR_HAVE_ADDR) ? r_awaddr : s_axi_lite_awaddr;
  assign w_wr_data = (r_wr_state == WR_HAVE_DATA) ? r_wdata : s_axi_lite_wdata;
  assign w_wr_strb = (r_wr_state == WR_HAVE_DATA) ? r_wstrb : s_axi_lite_wstrb;
  assign w_wr_idx  = (w_wr_addr - Base) >> 2;

  always_comb begin
    w_wr_resp = RespOkay;
    if (w_wr_addr < Base || w_wr_idx >= NumAll) w_wr_resp = RespDecErr;
    else if (w_wr_idx >= NumRw)                 w_wr_resp = RespSlvErr;
  end

  always_ff @(posedge s_axi_lite_aclk or posedge s_axi_lite_arst) begin
    if (s_axi_lite_arst) begin
      r_awaddr   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_bresp    <= RespOkay;
      r_wr_pulse <= '0;
      r_regs     <= '{default: '0};
    end else begin
      r_wr_pulse <= '0;
      if (s_axi_lite_awvalid && s_axi_lite_awready) r_awaddr <= s_axi_lite_awaddr;
      if (s_axi_lite_wvalid && s_axi_lite_wready) begin
        r_wdata <= s_axi_lite_wdata;
        r_wstrb <= s_axi_lite_wstrb;
      end
      if (w_commit) begin
        r_bresp <= w_wr_resp;
        if (w_wr_resp == RespOkay && |w_wr_strb) begin
          r_wr_pulse[w_wr_idx[IdxW-1:0]] <= 1'b1;
          for (int k = 0; k < int'(StrbW); k++) begin
            if (w_wr_strb[k]) r_regs[w_wr_idx[IdxW-1:0]][8*k +: 8] <= w_wr_data[8*k +: 8];
          end
        end
      end
    end
  end

  assign s_axi_lite_bvalid = (r_wr_state == WR_RESP);
  assign s_axi_lite_bresp  = r_bresp;

  // Read FSM
  always_ff @(posedge s_axi_lite_aclk or posedge s_axi_lite_arst) begin
    if (s_axi_lite_arst) r_rd_state <= RD_IDLE;
    else                 r_rd_state <= w_rd_state_nxt;
  end

  always_comb begin
    w_rd_state_nxt     = r_rd_state;
    s_axi_lite_arready = 1'b0;
    unique case (r_rd_state)
      RD_IDLE: begin
        s_axi_lite_arready = 1'b1;
        if (s_axi_lite_arvalid) w_rd_state_nxt = RD_RESP;
      end
      RD_RESP: begin
        if (s_axi_lite_rready) w_rd_state_nxt = RD_IDLE;
      end
    endcase
  end

  assign w_rd_idx = (s_axi_lite_araddr - Base) >> 2;

  always_comb begin
    w_rd_resp = RespOkay;
    w_rd_data = '0;
    if (s_axi_lite_araddr < Base || w_rd_idx >= NumAll) begin
      w_rd_resp = RespDecErr;
    end else if (w_rd_idx >= NumRw) begin
      unique case (2'(w_rd_idx - NumRw))
        2'd0: w_rd_data = DataW'(num_send_pkt_rcvd);
        2'd1: w_rd_data = DataW'(num_rd_resp_pkt_rcvd);
        2'd2: w_rd_data = DataW'(num_rdma_rd_wr_wqe);
        2'd3: w_rd_data = DataW'(num_ack_rcvd);
      endcase
    end else begin
      w_rd_data = r_regs[w_rd_idx[IdxW-1:0]];
    end
  end

  // Sampled before any same-edge write commit lands, so a colliding read sees the old value.
  always_ff @(posedge s_axi_lite_aclk or posedge s_axi_lite_arst) begin
    if (s_axi_lite_arst) begin
      r_rdata <= '0;
      r_rresp <= RespOkay;
    end else if (s_axi_lite_arvalid && s_axi_lite_arready) begin
      r_rdata <= w_rd_data;
      r_rresp <= w_rd_resp;
    end
  end

  assign s_axi_lite_rvalid = (r_rd_state == RD_RESP);
  assign s_axi_lite_rdata  = r_rdata;
  assign s_axi_lite_rresp  = r_rresp;

  always_comb begin
    reg_out = '0;
    for (int i = 0; i < int'(NUM_RW_REGS); i++) reg_out[DataW*i +: DataW] = r_regs[i];
  end
  assign reg_wr_pulse = r_wr_pulse;

endmodule
